// File: rtl/id_alu_decode_pkg.sv
// Shared ALU-decode definitions: ALUCode values, RV32I opcodes, operand-B selects
// and immediate formats. The EX stage imports the same package.
package id_alu_decode_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_LUI  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_OR   = 4'd5;
   localparam logic [3:0] ALU_SLL  = 4'd6;
   localparam logic [3:0] ALU_SRL  = 4'd7;
   localparam logic [3:0] ALU_SRA  = 4'd8;
   localparam logic [3:0] ALU_SLT  = 4'd9;
   localparam logic [3:0] ALU_SLTU = 4'd10;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;

   typedef enum logic [2:0] {
      FMT_NONE,
      FMT_I,
      FMT_SH,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } imm_fmt_e;

   // alt selects sub/sra; callers only set it where the alternate form exists
   function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
      logic [3:0] code;
      case (funct3)
         3'b000:  code = alt ? ALU_SUB : ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_SLT;
         3'b011:  code = ALU_SLTU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = alt ? ALU_SRA : ALU_SRL;
         3'b110:  code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/id_alu_decode_if.sv
// ALUCode bundle between the ID/EX register (master) and the EX stage (slave).
// The illegal flag exists only when ILLEGAL_TRAP_EN is defined.
interface id_alu_decode_if;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  ALUCode;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [31:0] Imm;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic        RegWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        Branch;
   logic        Jump;
   logic [31:0] pc_out;
`ifdef ILLEGAL_TRAP_EN
   logic        illegal;
`endif

   modport master (
`ifdef ILLEGAL_TRAP_EN
      output illegal,
`endif
      output out_valid, ALUCode, ALUSrcA, ALUSrcB, Imm, rs1, rs2, rd,
      output RegWrite, MemRead, MemWrite, Branch, Jump, pc_out,
      input  out_ready
   );

   modport slave (
`ifdef ILLEGAL_TRAP_EN
      input  illegal,
`endif
      input  out_valid, ALUCode, ALUSrcA, ALUSrcB, Imm, rs1, rs2, rd,
      input  RegWrite, MemRead, MemWrite, Branch, Jump, pc_out,
      output out_ready
   );
endinterface

// File: rtl/id_alu_decode_imm_gen.sv
// Immediate expander: builds the 32-bit operand for the format chosen by the decoder.
module imm_gen
   import id_alu_decode_pkg::*;
(
   input  logic [31:0] instr,
   input  imm_fmt_e    fmt,
   output logic [31:0] imm
);

   always_comb begin
      imm = '0;
      case (fmt)
         FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
         FMT_SH:  imm = {27'd0, instr[24:20]};
         FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm = {instr[31:12], 12'd0};
         FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/id_alu_decode.sv
// RV32I ID-stage ALU decoder with valid/ready ID/EX register and flush.
// Define ILLEGAL_TRAP_EN to add the illegal-instruction flag and its checker.
module id_alu_decode
   import id_alu_decode_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [31:0]     pc,
   input  logic            flush,
   id_alu_decode_if.master ex
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [3:0]  dec_alu;
   logic        dec_srca;
   logic [1:0]  dec_srcb;
   imm_fmt_e    dec_fmt;
   logic [31:0] dec_imm;
   logic        dec_rw, dec_mr, dec_mw, dec_br, dec_jp;
   logic        kill;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign in_ready = ~ex.out_valid | ex.out_ready;

   imm_gen u_imm_gen (
      .instr (instr),
      .fmt   (dec_fmt),
      .imm   (dec_imm)
   );

   always_comb begin
      dec_alu  = ALU_ADD;
      dec_srca = 1'b0;
      dec_srcb = SRCB_RS2;
      dec_fmt  = FMT_NONE;
      dec_rw   = 1'b0;
      dec_mr   = 1'b0;
      dec_mw   = 1'b0;
      dec_br   = 1'b0;
      dec_jp   = 1'b0;
      case (opcode)
         OP_REG: begin
            dec_alu = alu_from_funct3(funct3, instr[30]);
            dec_rw  = 1'b1;
         end
         OP_IMM: begin
            dec_alu  = alu_from_funct3(funct3, (funct3 == 3'b101) & instr[30]);
            dec_srcb = SRCB_IMM;
            dec_rw   = 1'b1;
            if (funct3[1:0] == 2'b01) dec_fmt = FMT_SH;
            else                      dec_fmt = FMT_I;
         end
         OP_LUI: begin
            dec_alu  = ALU_LUI;
            dec_srcb = SRCB_IMM;
            dec_fmt  = FMT_U;
            dec_rw   = 1'b1;
         end
         OP_AUIPC: begin
            dec_srca = 1'b1;
            dec_srcb = SRCB_IMM;
            dec_fmt  = FMT_U;
            dec_rw   = 1'b1;
         end
         OP_LOAD: begin
            dec_srcb = SRCB_IMM;
            dec_fmt  = FMT_I;
            dec_mr   = 1'b1;
            dec_rw   = 1'b1;
         end
         OP_STORE: begin
            dec_srcb = SRCB_IMM;
            dec_fmt  = FMT_S;
            dec_mw   = 1'b1;
         end
         OP_BRANCH: begin
            // beq/bne -> sub, blt/bge -> slt, bltu/bgeu -> sltu
            if (!funct3[2])     dec_alu = ALU_SUB;
            else if (funct3[1]) dec_alu = ALU_SLTU;
            else                dec_alu = ALU_SLT;
            dec_fmt = FMT_B;
            dec_br  = 1'b1;
         end
         OP_JAL, OP_JALR: begin
            dec_srca = 1'b1;
            dec_srcb = SRCB_FOUR;
            dec_jp   = 1'b1;
            dec_rw   = 1'b1;
            if (opcode == OP_JAL) dec_fmt = FMT_J;
            else                  dec_fmt = FMT_I;
         end
         default: ;
      endcase
      if (instr[11:7] == 5'd0) dec_rw = 1'b0;
   end

`ifdef ILLEGAL_TRAP_EN
   logic dec_illegal;

   always_comb begin
      dec_illegal = 1'b0;
      case (opcode)
         OP_REG:
            dec_illegal = (instr[31:25] != F7_BASE) && (instr[31:25] != F7_ALT);
         OP_IMM: begin
            if (funct3 == 3'b001)
               dec_illegal = (instr[31:25] != F7_BASE);
            else if (funct3 == 3'b101)
               dec_illegal = (instr[31:25] != F7_BASE) && (instr[31:25] != F7_ALT);
         end
         OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR:
            dec_illegal = 1'b0;
         default:
            dec_illegal = 1'b1;
      endcase
   end

   assign kill = dec_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  ex.illegal <= 1'b0;
      else if (flush)              ex.illegal <= 1'b0;
      else if (in_valid && in_ready) ex.illegal <= dec_illegal;
      else if (ex.out_ready)       ex.illegal <= 1'b0;
   end
`else
   assign kill = 1'b0;
`endif

   // Flags are cleared whenever the register goes empty so EX never sees stale controls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex.out_valid <= 1'b0;
         ex.ALUCode   <= ALU_ADD;
         ex.ALUSrcA   <= 1'b0;
         ex.ALUSrcB   <= SRCB_RS2;
         ex.Imm       <= '0;
         ex.rs1       <= '0;
         ex.rs2       <= '0;
         ex.rd        <= '0;
         ex.RegWrite  <= 1'b0;
         ex.MemRead   <= 1'b0;
         ex.MemWrite  <= 1'b0;
         ex.Branch    <= 1'b0;
         ex.Jump      <= 1'b0;
         ex.pc_out    <= '0;
      end else if (flush || (!(in_valid && in_ready) && ex.out_ready)) begin
         ex.out_valid <= 1'b0;
         ex.RegWrite  <= 1'b0;
         ex.MemRead   <= 1'b0;
         ex.MemWrite  <= 1'b0;
         ex.Branch    <= 1'b0;
         ex.Jump      <= 1'b0;
      end else if (in_valid && in_ready) begin
         ex.out_valid <= 1'b1;
         ex.ALUCode   <= dec_alu;
         ex.ALUSrcA   <= dec_srca;
         ex.ALUSrcB   <= dec_srcb;
         ex.Imm       <= dec_imm;
         ex.rs1       <= instr[19:15];
         ex.rs2       <= instr[24:20];
         ex.rd        <= instr[11:7];
         ex.RegWrite  <= dec_rw & ~kill;
         ex.MemRead   <= dec_mr & ~kill;
         ex.MemWrite  <= dec_mw & ~kill;
         ex.Branch    <= dec_br & ~kill;
         ex.Jump      <= dec_jp & ~kill;
         ex.pc_out    <= pc;
      end
   end

endmodule

// File: tb/tb_id_alu_decode.sv
// Scoreboard bench for id_alu_decode: directed vectors, stall, flush, async reset, then random traffic.
module tb_id_alu_decode;

   typedef struct packed {
      logic [3:0]  alu;
      logic        srca;
      logic [1:0]  srcb;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
      logic        jp;
      logic [31:0] pc;
      logic        ill;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        flush;
   logic        act_ill;

   id_alu_decode_if bus ();

   id_alu_decode dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .instr    (instr),
      .pc       (pc),
      .flush    (flush),
      .ex       (bus.master)
   );

`ifdef ILLEGAL_TRAP_EN
   assign act_ill = bus.illegal;
`else
   assign act_ill = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   vectors = 0;
   int   errors  = 0;
   exp_t sb[$];
   bit   pend_push  = 1'b0;
   bit   pend_flush = 1'b0;
   exp_t pend_exp;

   // Reference decode built from the ISA field layout, with immediates assembled arithmetically.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
      exp_t        e;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
      logic [3:0]  tab [0:7];
      bit          bad;
      op    = ins[6:0];
      f3    = ins[14:12];
      f7    = ins[31:25];
      tab   = '{4'd0, 4'd6, 4'd9, 4'd10, 4'd4, 4'd7, 4'd5, 4'd3};
      imm_i = 32'($signed(ins) >>> 20);
      imm_s = (imm_i & ~32'h1F) | {27'd0, ins[11:7]};
      imm_b = (imm_s & ~32'h801) | ({31'd0, ins[7]} << 11);
      imm_u = ins & 32'hFFFFF000;
      imm_j = (imm_i & 32'hFFF00000) | (ins & 32'h000FF000) | ((ins >> 9) & 32'h800)
              | ((ins >> 20) & 32'h7FE);
      e     = '0;
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.rd  = ins[11:7];
      e.pc  = p;
      bad   = 1'b0;
      case (op)
         7'h33: begin
            e.alu = tab[f3];
            if (ins[30] && f3 == 3'd0) e.alu = 4'd1;
            if (ins[30] && f3 == 3'd5) e.alu = 4'd8;
            e.rw = 1'b1;
            bad  = !(f7 == 7'h00 || f7 == 7'h20);
         end
         7'h13: begin
            e.alu = tab[f3];
            if (ins[30] && f3 == 3'd5) e.alu = 4'd8;
            e.srcb = 2'd1;
            e.imm  = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : imm_i;
            e.rw   = 1'b1;
            bad    = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20));
         end
         7'h37: begin e.alu = 4'd2; e.srcb = 2'd1; e.imm = imm_u; e.rw = 1'b1; end
         7'h17: begin e.srca = 1'b1; e.srcb = 2'd1; e.imm = imm_u; e.rw = 1'b1; end
         7'h03: begin e.srcb = 2'd1; e.imm = imm_i; e.mr = 1'b1; e.rw = 1'b1; end
         7'h23: begin e.srcb = 2'd1; e.imm = imm_s; e.mw = 1'b1; end
         7'h63: begin
            e.alu = (f3 < 3'd4) ? 4'd1 : ((f3 < 3'd6) ? 4'd9 : 4'd10);
            e.imm = imm_b;
            e.br  = 1'b1;
         end
         7'h6F: begin e.srca = 1'b1; e.srcb = 2'd2; e.imm = imm_j; e.jp = 1'b1; e.rw = 1'b1; end
         7'h67: begin e.srca = 1'b1; e.srcb = 2'd2; e.imm = imm_i; e.jp = 1'b1; e.rw = 1'b1; end
         default: bad = 1'b1;
      endcase
      if (e.rd == 5'd0) e.rw = 1'b0;
`ifndef ILLEGAL_TRAP_EN
      bad = 1'b0;
`endif
      if (bad) begin
         e.ill = 1'b1;
         e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.jp = 1'b0;
      end
      return e;
   endfunction

   function automatic exp_t actual();
      exp_t a;
      a.alu  = bus.ALUCode;
      a.srca = bus.ALUSrcA;
      a.srcb = bus.ALUSrcB;
      a.imm  = bus.Imm;
      a.rs1  = bus.rs1;
      a.rs2  = bus.rs2;
      a.rd   = bus.rd;
      a.rw   = bus.RegWrite;
      a.mr   = bus.MemRead;
      a.mw   = bus.MemWrite;
      a.br   = bus.Branch;
      a.jp   = bus.Jump;
      a.pc   = bus.pc_out;
      a.ill  = act_ill;
      return a;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0]  ops [0:8];
      int          sel;
      ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
      r   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 9) r[6:0] = ops[sel];
      if ((r[6:0] == 7'h33 || r[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
         r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
      return r;
   endfunction

   // One clock of stimulus; the model's view of the register is updated at each edge.
   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] p,
                       input bit ordy, input bit fl);
      @(posedge clk);
      if (pend_flush)     sb.delete();
      else if (pend_push) sb.push_back(pend_exp);
      #1;
      in_valid      = v;
      instr         = ins;
      pc            = p;
      bus.out_ready = ordy;
      flush         = fl;
      pend_flush    = fl;
      pend_push     = v && !fl && (sb.size() == 0 || ordy);
      pend_exp      = model(ins, p);
   endtask

   task automatic check_zero(input string name);
      vectors++;
      if ({bus.out_valid, actual()} !== '0) begin
         errors++;
         $display("FAIL %s: out_valid=%0b payload=%h, required all zero", name, bus.out_valid, actual());
      end
   endtask

   task automatic do_reset();
      in_valid   = 1'b0;
      flush      = 1'b0;
      pend_push  = 1'b0;
      pend_flush = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_zero("async_reset");
      sb.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin : monitor
      bit   exp_v;
      exp_t act;
      forever begin
         @(negedge clk);
         exp_v = (sb.size() != 0);
         vectors++;
         if (bus.out_valid !== exp_v) begin
            errors++;
            $display("FAIL out_valid: got %0b required %0b at %0t", bus.out_valid, exp_v, $time);
         end
         vectors++;
         if (in_ready !== (!exp_v || bus.out_ready)) begin
            errors++;
            $display("FAIL in_ready: got %0b required %0b at %0t", in_ready, !exp_v || bus.out_ready, $time);
         end
         if (exp_v && bus.out_valid) begin
            act = actual();
            vectors++;
            if (act !== sb[0]) begin
               errors++;
               $display("FAIL payload: got %h required %h at %0t", act, sb[0], $time);
            end
         end
         if (!bus.out_valid) begin
            vectors++;
            if ({bus.RegWrite, bus.MemRead, bus.MemWrite, bus.Branch, bus.Jump, act_ill} !== 6'd0) begin
               errors++;
               $display("FAIL idle_flags: got %b required 000000 at %0t",
                        {bus.RegWrite, bus.MemRead, bus.MemWrite, bus.Branch, bus.Jump, act_ill}, $time);
            end
         end
         if (exp_v && bus.out_ready && !flush) void'(sb.pop_front());
      end
   end

   initial begin
      rst_n         = 1'b0;
      in_valid      = 1'b0;
      flush         = 1'b0;
      instr         = '0;
      pc            = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_zero("reset_state");
      @(negedge clk);
      #2 rst_n = 1'b1;

      step(1'b1, 32'h002081B3, 32'h0000_0100, 1'b1, 1'b0);  // add x3,x1,x2
      step(1'b1, 32'h402081B3, 32'h0000_0104, 1'b1, 1'b0);  // sub
      step(1'b1, 32'h40335293, 32'h0000_0108, 1'b1, 1'b0);  // srai x5,x6,3
      step(1'b1, 32'h123450B7, 32'h0000_010C, 1'b1, 1'b0);  // lui x1,0x12345
      step(1'b1, 32'h0020E463, 32'h0000_0110, 1'b1, 1'b0);  // bltu x1,x2,8
      step(1'b1, 32'hFFFFFFFF, 32'h0000_0114, 1'b1, 1'b0);  // unknown opcode

      // stall: EX refuses for three cycles while a new instruction waits
      step(1'b1, 32'h00A00093, 32'h0000_0200, 1'b1, 1'b0);
      repeat (3) step(1'b1, 32'h00B00113, 32'h0000_0204, 1'b0, 1'b0);
      step(1'b1, 32'h00B00113, 32'h0000_0204, 1'b1, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // flush with a same-cycle in_valid
      step(1'b1, 32'h00C00193, 32'h0000_0300, 1'b1, 1'b0);
      step(1'b1, 32'h00D00213, 32'h0000_0304, 1'b1, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // reset while a payload is held and another is being accepted
      step(1'b1, 32'h002081B3, 32'h0000_0400, 1'b1, 1'b0);
      step(1'b1, 32'h402081B3, 32'h0000_0404, 1'b0, 1'b0);
      do_reset();
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 9) < 7, rand_instr(), $urandom & 32'hFFFF_FFFC,
              $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
         if (i == 700) do_reset();
      end

      repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/id_alu_decode.md
# id_alu_decode

ID-stage instruction decoder and ID/EX pipeline register for the RV32I core. It turns a fetched 32-bit instruction into the 4-bit ALU operation code, operand-source selects, immediate and control flags consumed by the EX-stage ALU. It registers them behind a valid/ready handshake with flush support. It is the producer end of the ALUCode interface that the EX stage consumes.

## Interface
- No parameters; widths are fixed (XLEN 32).
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  instr/pc valid from IF/ID
- in_ready  out  1  stage can accept instruction this cycle
- instr  in  32  raw instruction
- pc  in  32  instruction address
- flush  in  1  kill the ID/EX contents (branch taken / redirect)
- out_valid  out  1  EX-side payload valid
- out_ready  in  1  EX stage accepts payload
- ALUCode  out  4  ALU operation (encodings under Operation)
- ALUSrcA  out  1  0 = rs1, 1 = PC
- ALUSrcB  out  2  0 = rs2, 1 = Imm, 2 = constant 4
- Imm  out  32  sign/format-expanded immediate
- rs1, rs2, rd  out  5 each  register indices
- RegWrite, MemRead, MemWrite, Branch, Jump  out  1 each  control flags
- pc_out  out  32  registered pc
- illegal  out  1  illegal-instruction flag (present only with ILLEGAL_TRAP_EN)

## Operation
- ALUCode encodings:
  - add 0
  - sub 1
  - lui 2
  - and 3
  - xor 4
  - or 5
  - sll 6
  - srl 7
  - sra 8
  - slt 9
  - sltu 10
- R-type (0110011), by funct3:
  - 000: add, or sub when instr[30]=1
  - 001: sll
  - 010: slt
  - 011: sltu
  - 100: xor
  - 101: srl, or sra when instr[30]=1
  - 110: or
  - 111: and
- R-type controls: ALUSrcB=0, RegWrite=1.
- OP-IMM (0010011): same mapping as R-type, except funct3 000 is always add. Shifts use instr[30] for sra; Imm = zero-extended shamt. ALUSrcB=1.
- LUI (0110111): ALUCode=lui, ALUSrcB=1, Imm = {instr[31:12],12'b0}.
- AUIPC (0010111): add, ALUSrcA=1, ALUSrcB=1.
- LOAD (0000011) / STORE (0100011): add, ALUSrcB=1, with MemRead or MemWrite respectively.
- BRANCH (1100011), by funct3:
  - beq/bne: sub
  - blt/bge: slt
  - bltu/bgeu: sltu
  - Branch=1, ALUSrcB=0, Imm = B-format.
- JAL (1101111) / JALR (1100111): add, ALUSrcA=1, ALUSrcB=2 (link = PC+4), Jump=1, RegWrite=1. Imm = J-format or I-format respectively.
- Imm sign-extended from instr[31] for I/S/B/U/J formats.
- Any other opcode: ALUCode=add, all control flags 0 (bubble semantics).
- RegWrite is forced 0 when rd==0.

## Timing
- Latency: 1 cycle; decode is combinational on the input, captured at the clock edge on an accepted transfer.
- in_ready = ~out_valid | out_ready.
- Transfer in occurs when in_valid & in_ready; transfer out occurs when out_valid & out_ready.
- Stall (out_valid & ~out_ready): all outputs hold.
- flush has priority over everything:
  - next cycle out_valid=0 and all control flags 0
  - an in_valid asserted in the same cycle is dropped
- When out_valid=0, control flags are 0 regardless of other fields.
- Reset values: out_valid 0, ALUCode 0, ALUSrcA 0, ALUSrcB 0, Imm 0, rs1/rs2/rd 0, all flags 0, pc_out 0, illegal 0.
- Reset mid-transfer discards the payload.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - illegal port exists.
  - It is asserted with out_valid for unknown opcodes, for funct7 not in {0000000,0100000} on R-type, and for bad shift funct7.
  - The flagged instruction still leaves with all control flags 0.
- ILLEGAL_TRAP_EN undefined: no illegal port, no checking logic; unknown opcodes silently become bubbles.

## Structure
- Shared package holds:
  - ALUCode constants (ALU_ADD … ALU_SLTU)
  - opcode constants
  - ALUSrcB select constants
- These are shared with the EX stage.
- One sub-module: imm_gen (combinational instruction → Imm and format select).
- The decode table and pipeline register live in id_alu_decode.

## Test plan
- 0x002081B3 (add x3,x1,x2), out_ready=1 → next cycle out_valid=1, ALUCode=0, rd=3, rs1=1, rs2=2, RegWrite=1, ALUSrcB=0.
- 0x402081B3 (sub) → ALUCode=1. 0x40335293 (srai x5,x6,3) → ALUCode=8, Imm=3, ALUSrcB=1.
- 0x123450B7 (lui x1,0x12345) → ALUCode=2, Imm=0x12345000. bltu instruction → ALUCode=10, Branch=1, RegWrite=0.
- Hold out_ready=0 for 3 cycles with new instr presented → in_ready=0 and outputs unchanged. Then release → the queued instruction appears one cycle later.
- flush with in_valid=1 in the same cycle → out_valid=0 next cycle, all flags 0. rst_n pulsed low mid-stream → all outputs 0 asynchronously.
- 0xFFFFFFFF → bubble (flags 0), and illegal=1 only when ILLEGAL_TRAP_EN is defined.
